// File: rtl/spi_ctrl_regs_pkg.sv
// spi_ctrl_pkg
//   Shared definitions for the SPI control-register bank:
//     - state_e      : FSM state encoding (IDLE / SHIFT)
//     - calc_frame_w : frame length in bits (address + data)
//     - calc_cnt_w   : bit-counter width, wide enough to hold FRAME_W+1
//                      (the saturated overrun marker)
package spi_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int calc_frame_w(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    // Counter must represent 0..FRAME_W+1, i.e. FRAME_W+2 distinct values.
    function automatic int calc_cnt_w(input int frame_w);
        return $clog2(frame_w + 2);
    endfunction

endpackage

// File: rtl/spi_ctrl_regs_sync.sv
// spi_sync
//   STAGES-deep synchroniser for one asynchronous input, followed by
//   rise/fall detection of the last synced stage against a one-cycle
//   delayed copy.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     async_in in   asynchronous input pin
//     level    out  synchronised level (last stage)
//     rise     out  1 for one cycle when level goes 0 -> 1
//     fall     out  1 for one cycle when level goes 1 -> 0
//   All flops reset to 0. For SS this means a slave select that is already
//   low at reset release produces no falling edge, so no frame starts until
//   SS has been seen high and then low.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_ctrl_regs.sv
// spi_ctrl_regs
//   SPI mode-0 slave that receives address+data frames (MSB first, address
//   then data) and writes them into NUM_REGS control registers. A frame is
//   committed atomically when SS deasserts; malformed frames are rejected.
//   Ports:
//     clock      in   system clock
//     reset      in   asynchronous active-low reset
//     SCLK       in   SPI clock (asynchronous)
//     MOSI       in   SPI data (asynchronous)
//     SS         in   SPI slave select, active-low (asynchronous)
//     reg_out    out  flattened registers, reg i at [i*DATA_W +: DATA_W]
//     wr_strobe  out  one-cycle pulse on a committed write
//     wr_addr    out  address of the last committed write
//     frame_err  out  one-cycle pulse on a rejected frame
//     busy       out  high while in SHIFT (registered copy of FSM state)
//   Output handshake: wr_strobe and frame_err are single-cycle event
//   pulses with no ready/back-pressure; they are mutually exclusive and
//   reg_out/wr_addr are already updated in the cycle the pulse is high,
//   so a consumer samples everything together in that one cycle.
//   busy doubles as the observable FSM state (1 = SHIFT, 0 = IDLE).
module spi_ctrl_regs
    import spi_ctrl_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                NUM_REGS    = 4,
    parameter int                ADDR_W      = 2,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       SCLK,
    input  logic                       MOSI,
    input  logic                       SS,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int FRAME_W = calc_frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = calc_cnt_w(FRAME_W);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_OVR   = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]   NREGS_CMP = (ADDR_W + 1)'(NUM_REGS);

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_lvl, ss_rise, ss_fall;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk      (clock),
        .rst_n    (reset),
        .async_in (SCLK),
        .level    (sclk_lvl),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk      (clock),
        .rst_n    (reset),
        .async_in (MOSI),
        .level    (mosi_lvl),
        .rise     (mosi_rise),
        .fall     (mosi_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk      (clock),
        .rst_n    (reset),
        .async_in (SS),
        .level    (ss_lvl),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    // Edge/level outputs this block has no use for.
    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, sclk_fall, mosi_rise, mosi_fall, ss_lvl};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [FRAME_W-1:0]                    shreg_q, shreg_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]       regs_q, regs_d;
    logic                                  wr_strobe_q, wr_strobe_d;
    logic                                  frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]                     wr_addr_q, wr_addr_d;
    logic                                  busy_q, busy_d;

    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;

    assign frame_addr = shreg_q[FRAME_W-1 -: ADDR_W];
    assign frame_data = shreg_q[DATA_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            SHIFT: begin
                // SS rise takes priority over a coincident SCLK rise: the
                // frame is judged on what has been shifted so far.
                if (ss_rise) begin
                    state_d = IDLE;
                    if ((cnt_q == CNT_FULL) && ({1'b0, frame_addr} < NREGS_CMP)) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if ({1'b0, frame_addr} == (ADDR_W + 1)'(i)) begin
                                regs_d[i] = frame_data;
                            end
                        end
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = frame_addr;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_W-2:0], mosi_lvl};
                    // Saturate one past full so any extra clock is remembered.
                    if (cnt_q != CNT_OVR) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_ctrl_regs.sv
// tb_spi_ctrl_regs
//   Drives SPI frames into two instances of spi_ctrl_regs that share the
//   SPI pins: dut_a with NUM_REGS=4 and dut_b with NUM_REGS=3, so the
//   out-of-range address path is exercised alongside the normal one.
//   Expected events are derived from frame length/address rules and pushed
//   to per-instance queues; a monitor pops and compares on each pulse.
module tb_spi_ctrl_regs;

    localparam int W = 35;  // {frame_err, wr_addr[1:0], reg_out padded to 32}

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic mosi  = 1'b0;
    logic ss    = 1'b1;

    always #5 clock = ~clock;

    logic [31:0] reg_out_a;
    logic        wr_strobe_a, frame_err_a, busy_a;
    logic [1:0]  wr_addr_a;
    logic [23:0] reg_out_b;
    logic        wr_strobe_b, frame_err_b, busy_b;
    logic [1:0]  wr_addr_b;

    spi_ctrl_regs #(
        .DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .SYNC_STAGES(2), .RESET_VAL(8'h00)
    ) dut_a (
        .clock(clock), .reset(rst_n), .SCLK(sclk), .MOSI(mosi), .SS(ss),
        .reg_out(reg_out_a), .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a),
        .frame_err(frame_err_a), .busy(busy_a)
    );

    spi_ctrl_regs #(
        .DATA_W(8), .NUM_REGS(3), .ADDR_W(2), .SYNC_STAGES(2), .RESET_VAL(8'h00)
    ) dut_b (
        .clock(clock), .reset(rst_n), .SCLK(sclk), .MOSI(mosi), .SS(ss),
        .reg_out(reg_out_b), .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b),
        .frame_err(frame_err_b), .busy(busy_b)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];

    logic [7:0] model_a[4];
    logic [7:0] model_b[3];
    logic [1:0] last_a, last_b;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model_a[i] = 8'h00;
        for (int i = 0; i < 3; i++) model_b[i] = 8'h00;
        last_a = 2'd0;
        last_b = 2'd0;
    endtask

    function automatic logic [31:0] flat_a();
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 4; i++) f[i*8 +: 8] = model_a[i];
        return f;
    endfunction

    function automatic logic [31:0] flat_b();
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 3; i++) f[i*8 +: 8] = model_b[i];
        return f;
    endfunction

    // A frame of n bits carrying v: only exactly 10 bits with an address
    // below the register count is a write; everything else is an error.
    task automatic model_frame(input logic [31:0] v, input int n);
        logic [1:0] addr;
        logic [7:0] data;
        logic       err_a, err_b;
        addr  = v[9:8];
        data  = v[7:0];
        err_a = !(n == 10 && int'(addr) < 4);
        err_b = !(n == 10 && int'(addr) < 3);
        if (!err_a) begin
            model_a[addr] = data;
            last_a        = addr;
        end
        if (!err_b) begin
            model_b[addr] = data;
            last_b        = addr;
        end
        exp_q_a.push_back({err_a, last_a, flat_a()});
        exp_q_b.push_back({err_b, last_b, flat_b()});
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    always @(negedge clock) begin
        if (rst_n) begin
            if (wr_strobe_a || frame_err_a) begin
                check("a_exclusive", {34'b0, wr_strobe_a & frame_err_a}, '0);
                check("a_pulse_width", {34'b0, prev_a}, '0);
                if (exp_q_a.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL a_unexpected_pulse: got strobe=%0b err=%0b expected no event",
                             wr_strobe_a, frame_err_a);
                end else begin
                    check("a_event", {frame_err_a, wr_addr_a, reg_out_a}, exp_q_a.pop_front());
                end
            end
            if (wr_strobe_b || frame_err_b) begin
                check("b_exclusive", {34'b0, wr_strobe_b & frame_err_b}, '0);
                check("b_pulse_width", {34'b0, prev_b}, '0);
                if (exp_q_b.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL b_unexpected_pulse: got strobe=%0b err=%0b expected no event",
                             wr_strobe_b, frame_err_b);
                end else begin
                    check("b_event", {frame_err_b, wr_addr_b, 8'h00, reg_out_b}, exp_q_b.pop_front());
                end
            end
            prev_a = wr_strobe_a | frame_err_a;
            prev_b = wr_strobe_b | frame_err_b;
        end else begin
            prev_a = 1'b0;
            prev_b = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (all pin changes happen on the falling clock edge)
    // ------------------------------------------------------------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_start();
        ss = 1'b0;
        wait_clks(4);
        check("busy_in_frame", {33'b0, busy_a, busy_b}, 35'd3);
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            wait_clks(4);
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end(input int gap);
        wait_clks(4);
        ss = 1'b1;
        wait_clks(gap);
        check("busy_after_frame", {33'b0, busy_a, busy_b}, '0);
    endtask

    task automatic frame(input logic [31:0] v, input int n, input int gap);
        spi_start();
        spi_bits(v, n);
        model_frame(v, n);
        spi_end(gap);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_a"}, {wr_strobe_a, frame_err_a, busy_a, wr_addr_a, reg_out_a}, '0);
        check({name, "_b"}, {wr_strobe_b, frame_err_b, busy_b, wr_addr_b, reg_out_b}, '0);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;
        logic found;
        logic [31:0] v;
        int n;

        model_reset();
        #1;
        check_reset_state("reset_state");
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(6);

        // Valid write to reg1.
        frame(32'h1A5, 10, 6);
        // Short frame: 9 bits.
        frame(32'h1FF, 9, 6);
        // Overrun: 11 bits, then a valid write to reg3.
        frame(32'h7FF, 11, 6);
        frame(32'h30F, 10, 6);
        // Address 3: valid for dut_a, out of range for dut_b.
        frame(32'h355, 10, 6);
        // SS pulse with no clocks.
        frame(32'h000, 0, 6);

        // Reset in the middle of a frame.
        spi_start();
        spi_bits(32'h015, 5);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("reset_mid_frame");
        wait_clks(2);
        rst_n = 1'b1;
        // SS still low: these bits must be ignored, and the SS rise too.
        spi_bits(32'h01F, 5);
        spi_end(6);
        frame(32'h03C, 10, 6);

        // Back-to-back writes with a 4-clock SS-high gap.
        frame(32'h211, 10, 4);
        frame(32'h222, 10, 6);

        // Latency from first sample of SS high to wr_strobe.
        spi_start();
        spi_bits(32'h15A, 10);
        model_frame(32'h15A, 10);
        wait_clks(4);
        ss    = 1'b1;
        lat   = 0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clock);
            lat++;
            #1;
            if (wr_strobe_a) found = 1'b1;
        end
        check("strobe_latency", W'(lat), W'(3));
        wait_clks(6);

        // Randomised frames with idle-time SCLK/MOSI noise.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2)) begin
                mosi = 1'($urandom);
                sclk = 1'b1;
                wait_clks(4);
                sclk = 1'b0;
                wait_clks(4);
            end
            v = $urandom;
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = 9;
                2:       n = 11;
                default: n = 10;
            endcase
            frame(v, n, $urandom_range(4, 8));
        end

        wait_clks(10);
        check("queue_a_drained", W'(exp_q_a.size()), '0);
        check("queue_b_drained", W'(exp_q_b.size()), '0);
        check("final_regs_a", {3'b0, reg_out_a}, {3'b0, flat_a()});
        check("final_regs_b", {11'b0, reg_out_b}, {3'b0, flat_b()});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
